// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART_TX among NUM_REQ byte producers.
// Optional inter-frame idle gap is built only when UART_ARB_GAP_EN is defined.
module uart_tx_arbiter #(
  parameter int IN_WIDTH     = 8,
  parameter int NUM_REQ      = 4,
  parameter int ID_WIDTH     = 2,
  parameter int BUSY_TIMEOUT = 4,
  parameter int GAP_CYCLES   = 2
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [NUM_REQ-1:0]           REQ_VALID,
  input  logic [NUM_REQ*IN_WIDTH-1:0]  REQ_DATA,
  output logic [NUM_REQ-1:0]           REQ_ACK,
  input  logic                         TX_BUSY,
  output logic [IN_WIDTH-1:0]          P_DATA,
  output logic                         Data_Valid,
  output logic [ID_WIDTH-1:0]          GRANT_ID,
  output logic                         ARB_BUSY,
  output logic                         TO_ERR,
  output logic [1:0]                   DBG_STATE
);

  // Handshake: a requester holds REQ_VALID/REQ_DATA until its REQ_ACK pulse; the
  // arbiter launches with a one-cycle Data_Valid and then waits for TX_BUSY to rise and fall.

  if (ID_WIDTH < $clog2(NUM_REQ) || NUM_REQ < 2 || BUSY_TIMEOUT < 1 || GAP_CYCLES < 0) begin : g_param_err
    $error("uart_tx_arbiter: illegal parameter combination");
  end

  localparam int TO_W = (BUSY_TIMEOUT < 2) ? 1 : $clog2(BUSY_TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_DONE = 2'd2
`ifdef UART_ARB_GAP_EN
    , ST_GAP     = 2'd3
`endif
  } state_t;

  state_t                r_state;
  logic [ID_WIDTH-1:0]   r_rr_ptr;
  logic [TO_W-1:0]       r_to_cnt;
  logic [NUM_REQ-1:0]    r_ack;
  logic [IN_WIDTH-1:0]   r_p_data;
  logic                  r_dv;
  logic [ID_WIDTH-1:0]   r_grant_id;
  logic                  r_arb_busy;
  logic                  r_to_err;

`ifdef UART_ARB_GAP_EN
  localparam int GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
  logic [GAP_W-1:0]      r_gap_cnt;
`endif

  logic                  w_found;
  logic [ID_WIDTH-1:0]   w_win;
  logic [IN_WIDTH-1:0]   w_win_data;
  logic [NUM_REQ-1:0]    w_win_onehot;
  logic [ID_WIDTH-1:0]   w_next_ptr;

  // Scan from the round-robin pointer upward, wrapping; the first pending bit wins.
  always_comb begin
    int v_idx;
    w_found      = 1'b0;
    w_win        = '0;
    w_win_data   = '0;
    w_win_onehot = '0;
    v_idx        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      v_idx = (int'(r_rr_ptr) + k) % NUM_REQ;
      if (!w_found && REQ_VALID[v_idx]) begin
        w_found             = 1'b1;
        w_win               = ID_WIDTH'(v_idx);
        w_win_data          = REQ_DATA[v_idx*IN_WIDTH +: IN_WIDTH];
        w_win_onehot[v_idx] = 1'b1;
      end
    end
    w_next_ptr = (int'(w_win) == NUM_REQ-1) ? '0 : w_win + ID_WIDTH'(1);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= '0;
      r_to_cnt   <= '0;
      r_ack      <= '0;
      r_p_data   <= '0;
      r_dv       <= 1'b0;
      r_grant_id <= '0;
      r_arb_busy <= 1'b0;
      r_to_err   <= 1'b0;
`ifdef UART_ARB_GAP_EN
      r_gap_cnt  <= '0;
`endif
    end else begin
      r_ack    <= '0;
      r_dv     <= 1'b0;
      r_to_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // A busy UART here means someone else owns it; hold off the launch.
          if (w_found && !TX_BUSY) begin
            r_p_data   <= w_win_data;
            r_grant_id <= w_win;
            r_ack      <= w_win_onehot;
            r_dv       <= 1'b1;
            r_rr_ptr   <= w_next_ptr;
            r_to_cnt   <= '0;
            r_arb_busy <= 1'b1;
            r_state    <= ST_WAIT_BUSY;
          end
        end
        ST_WAIT_BUSY: begin
          if (TX_BUSY) begin
            r_state <= ST_WAIT_DONE;
          end else if (r_to_cnt == TO_W'(BUSY_TIMEOUT-1)) begin
            r_to_err   <= 1'b1;
            r_arb_busy <= 1'b0;
            r_state    <= ST_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (!TX_BUSY) begin
`ifdef UART_ARB_GAP_EN
            if (GAP_CYCLES > 0) begin
              r_gap_cnt <= '0;
              r_state   <= ST_GAP;
            end else begin
              r_arb_busy <= 1'b0;
              r_state    <= ST_IDLE;
            end
`else
            r_arb_busy <= 1'b0;
            r_state    <= ST_IDLE;
`endif
          end
        end
`ifdef UART_ARB_GAP_EN
        ST_GAP: begin
          if (r_gap_cnt == GAP_W'(GAP_CYCLES-1)) begin
            r_arb_busy <= 1'b0;
            r_state    <= ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
          end
        end
`endif
        default: begin
          r_arb_busy <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign REQ_ACK    = r_ack;
  assign P_DATA     = r_p_data;
  assign Data_Valid = r_dv;
  assign GRANT_ID   = r_grant_id;
  assign ARB_BUSY   = r_arb_busy;
  assign TO_ERR     = r_to_err;
  assign DBG_STATE  = r_state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a small UART_TX busy model, a round-robin reference
// and a byte scoreboard. Compile with UART_ARB_GAP_EN to exercise the inter-frame gap.
module tb_uart_tx_arbiter;
  localparam int IN_WIDTH     = 8;
  localparam int NUM_REQ      = 4;
  localparam int ID_WIDTH     = 2;
  localparam int BUSY_TIMEOUT = 4;
  localparam int GAP_CYCLES   = 2;
`ifdef UART_ARB_GAP_EN
  localparam int EXP_GAP = 2 + GAP_CYCLES;
`else
  localparam int EXP_GAP = 2;
`endif

  logic                        CLK;
  logic                        RST;
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ*IN_WIDTH-1:0] req_data;
  logic [IN_WIDTH-1:0]         req_byte [NUM_REQ];
  logic [NUM_REQ-1:0]          REQ_ACK;
  logic                        TX_BUSY;
  logic [IN_WIDTH-1:0]         P_DATA;
  logic                        Data_Valid;
  logic [ID_WIDTH-1:0]         GRANT_ID;
  logic                        ARB_BUSY;
  logic                        TO_ERR;
  logic [1:0]                  dbg_state;

  int checks;
  int failures;
  int model_ptr;
  logic [IN_WIDTH-1:0] exp_q[$];
  logic [IN_WIDTH-1:0] rx_q[$];

  uart_tx_arbiter #(
    .IN_WIDTH(IN_WIDTH), .NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH),
    .BUSY_TIMEOUT(BUSY_TIMEOUT), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .CLK(CLK), .RST(RST), .REQ_VALID(req_valid), .REQ_DATA(req_data),
    .REQ_ACK(REQ_ACK), .TX_BUSY(TX_BUSY), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
    .GRANT_ID(GRANT_ID), .ARB_BUSY(ARB_BUSY), .TO_ERR(TO_ERR), .DBG_STATE(dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) req_data[i*IN_WIDTH +: IN_WIDTH] = req_byte[i];
  end

  // ---------------- UART_TX stand-in ----------------
  int   tx_cnt;
  logic uart_en;
  logic ext_busy;
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tx_cnt <= 0;
    end else if (uart_en && Data_Valid) begin
      tx_cnt <= int'($urandom_range(3, 8));
      rx_q.push_back(P_DATA);
    end else if (tx_cnt > 0) begin
      tx_cnt <= tx_cnt - 1;
    end
  end
  assign TX_BUSY = (tx_cnt > 0) || ext_busy;

  // ---------------- reference: round-robin pick ----------------
  function automatic int rr_pick(input int ptr, input logic [NUM_REQ-1:0] mask);
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (ptr + k) % NUM_REQ;
      if (mask[idx]) return idx;
    end
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge CLK);
  endtask

  task automatic apply_reset();
    req_valid = '0;
    ext_busy  = 1'b0;
    uart_en   = 1'b1;
    RST       = 1'b0;
    repeat (2) step();
    RST       = 1'b1;
    model_ptr = 0;
    step();
  endtask

  task automatic wait_launch(input int budget, output bit got, output int idle_cnt, output bit saw_busy);
    got = 1'b0; idle_cnt = 0; saw_busy = 1'b0;
    for (int c = 0; c < budget && !got; c++) begin
      step();
      if (Data_Valid) got = 1'b1;
      else if (TX_BUSY) begin saw_busy = 1'b1; idle_cnt = 0; end
      else if (saw_busy) idle_cnt++;
    end
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      step();
      if (!ARB_BUSY && !TX_BUSY) done = 1'b1;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s_idle: arbiter/uart still busy after 60 cycles, required idle", name);
    end
  endtask

  task automatic check_launch(input string name, input int w, input logic [IN_WIDTH-1:0] exp_byte);
    logic [NUM_REQ-1:0] exp_ack;
    exp_ack = '0;
    if (w >= 0) exp_ack[w] = 1'b1;
    checks++;
    if (int'(GRANT_ID) !== w) begin
      failures++; $display("FAIL %s_grant: got %0d required %0d", name, GRANT_ID, w);
    end
    checks++;
    if (P_DATA !== exp_byte) begin
      failures++; $display("FAIL %s_pdata: got %0h required %0h", name, P_DATA, exp_byte);
    end
    checks++;
    if (REQ_ACK !== exp_ack) begin
      failures++; $display("FAIL %s_ack: got %b required %b", name, REQ_ACK, exp_ack);
    end
  endtask

  task automatic check_scoreboard(input string name);
    logic [IN_WIDTH-1:0] e, r;
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL %s_frames: got %0d frames required %0d", name, rx_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front();
      r = rx_q.pop_front();
      checks++;
      if (r !== e) begin
        failures++; $display("FAIL %s_byte: got %0h required %0h", name, r, e);
      end
    end
    exp_q.delete();
    rx_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) step();
    checks++;
    if ({REQ_ACK, P_DATA, Data_Valid, GRANT_ID, ARB_BUSY, TO_ERR, dbg_state} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got ack=%b pdata=%0h dv=%b gid=%0d busy=%b to=%b st=%0d required all 0",
               REQ_ACK, P_DATA, Data_Valid, GRANT_ID, ARB_BUSY, TO_ERR, dbg_state);
    end
    RST = 1'b1;
    model_ptr = 0;
    repeat (2) step();
    checks++;
    if (Data_Valid !== 1'b0 || ARB_BUSY !== 1'b0) begin
      failures++; $display("FAIL reset_idle: got dv=%b busy=%b required 0 0", Data_Valid, ARB_BUSY);
    end
  endtask

  task automatic test_single();
    req_byte[1] = 8'hA5;
    req_valid   = 4'b0010;
    step();
    check_launch("single", 1, 8'hA5);
    checks++;
    if (Data_Valid !== 1'b1 || ARB_BUSY !== 1'b1) begin
      failures++; $display("FAIL single_dv: got dv=%b busy=%b required 1 1", Data_Valid, ARB_BUSY);
    end
    exp_q.push_back(8'hA5);
    model_ptr = 2;
    req_valid = '0;
    step();
    checks++;
    if (Data_Valid !== 1'b0 || REQ_ACK !== '0) begin
      failures++; $display("FAIL single_pulse: got dv=%b ack=%b required 0 0", Data_Valid, REQ_ACK);
    end
    wait_idle("single");
    checks++;
    if (P_DATA !== 8'hA5) begin
      failures++; $display("FAIL single_hold: got %0h required a5", P_DATA);
    end
    check_scoreboard("single");
  endtask

  task automatic test_round_robin();
    bit got, saw;
    int idle, w;
    logic [IN_WIDTH-1:0] base;
    apply_reset();
    base = 8'($urandom_range(0, 255));
    for (int i = 0; i < NUM_REQ; i++) req_byte[i] = base + 8'(i * 37);
    req_valid = '1;
    for (int f = 0; f < 9; f++) begin
      wait_launch(30, got, idle, saw);
      checks++;
      if (!got) begin
        failures++; $display("FAIL rr_launch: no Data_Valid in frame %0d within 30 cycles", f);
        return;
      end
      w = rr_pick(model_ptr, req_valid);
      check_launch("rr", w, req_byte[w]);
      if (f > 0) begin
        checks++;
        if (!saw || idle != EXP_GAP) begin
          failures++;
          $display("FAIL rr_gap: got %0d idle cycles (busy seen=%0b) required %0d", idle, saw, EXP_GAP);
        end
      end
      exp_q.push_back(req_byte[w]);
      model_ptr = (w + 1) % NUM_REQ;
      req_byte[w] = 8'($urandom_range(0, 255));
    end
    req_valid = '0;
    wait_idle("rr");
    check_scoreboard("rr");
  endtask

  task automatic test_wrap();
    bit got, saw;
    int idle;
    apply_reset();
    for (int i = 0; i < NUM_REQ; i++) req_byte[i] = 8'($urandom_range(0, 255));
    req_valid = 4'b0100;
    wait_launch(10, got, idle, saw);
    check_launch("wrap_pre", 2, req_byte[2]);
    exp_q.push_back(req_byte[2]);
    req_valid = 4'b1001;
    wait_launch(30, got, idle, saw);
    check_launch("wrap_3", 3, req_byte[3]);
    exp_q.push_back(req_byte[3]);
    req_valid = 4'b0001;
    wait_launch(30, got, idle, saw);
    check_launch("wrap_0", 0, req_byte[0]);
    exp_q.push_back(req_byte[0]);
    req_valid = 4'b0011;
    wait_launch(30, got, idle, saw);
    check_launch("wrap_ptr1", 1, req_byte[1]);
    exp_q.push_back(req_byte[1]);
    model_ptr = 2;
    req_valid = '0;
    wait_idle("wrap");
    check_scoreboard("wrap");
  endtask

  task automatic test_random();
    bit got, saw;
    int idle, w, worst;
    int waits [NUM_REQ];
    for (int i = 0; i < NUM_REQ; i++) waits[i] = 0;
    worst = 0;
    req_valid = '0;
    for (int f = 0; f < 24; f++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          req_valid[i] = 1'b1;
          req_byte[i]  = 8'($urandom_range(0, 255));
          waits[i]     = 0;
        end
      end
      if (req_valid == '0) begin
        w = int'($urandom_range(0, NUM_REQ-1));
        req_valid[w] = 1'b1;
        req_byte[w]  = 8'($urandom_range(0, 255));
        waits[w]     = 0;
      end
      wait_launch(30, got, idle, saw);
      checks++;
      if (!got) begin
        failures++; $display("FAIL rand_launch: no Data_Valid in frame %0d", f);
        req_valid = '0;
        return;
      end
      w = rr_pick(model_ptr, req_valid);
      check_launch("rand", w, req_byte[w]);
      exp_q.push_back(req_byte[w]);
      model_ptr = (w + 1) % NUM_REQ;
      req_valid[w] = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i]) begin
          waits[i]++;
          if (waits[i] > worst) worst = waits[i];
          if ($urandom_range(0, 7) == 0) req_valid[i] = 1'b0;
        end
      end
    end
    checks++;
    if (worst > NUM_REQ - 1) begin
      failures++; $display("FAIL rand_fair: got wait of %0d frames required <= %0d", worst, NUM_REQ-1);
    end
    req_valid = '0;
    wait_idle("rand");
    check_scoreboard("rand");
  endtask

  task automatic test_timeout();
    bit got, saw;
    int idle, seen_at, dv_cnt, w;
    wait_idle("to_pre");
    uart_en     = 1'b0;
    req_byte[0] = 8'($urandom_range(0, 255));
    req_valid   = 4'b0001;
    wait_launch(10, got, idle, saw);
    check_launch("to_launch", 0, req_byte[0]);
    model_ptr = 1;
    req_valid = '0;
    seen_at = -1;
    dv_cnt  = 0;
    for (int c = 1; c <= BUSY_TIMEOUT + 4 && seen_at < 0; c++) begin
      step();
      if (Data_Valid) dv_cnt++;
      if (TO_ERR) begin
        seen_at = c;
        checks++;
        if (ARB_BUSY !== 1'b0) begin
          failures++; $display("FAIL to_state: got ARB_BUSY=%b required 0", ARB_BUSY);
        end
      end
    end
    checks++;
    if (seen_at != BUSY_TIMEOUT) begin
      failures++; $display("FAIL to_latency: got %0d cycles required %0d", seen_at, BUSY_TIMEOUT);
    end
    step();
    checks++;
    if (TO_ERR !== 1'b0 || dv_cnt != 0 || Data_Valid !== 1'b0) begin
      failures++; $display("FAIL to_pulse: got to=%b relaunches=%0d required 0 0", TO_ERR, dv_cnt + int'(Data_Valid));
    end
    uart_en     = 1'b1;
    req_byte[2] = 8'($urandom_range(0, 255));
    req_valid   = 4'b0100;
    wait_launch(10, got, idle, saw);
    w = rr_pick(model_ptr, 4'b0100);
    check_launch("to_after", w, req_byte[2]);
    exp_q.push_back(req_byte[2]);
    model_ptr = (w + 1) % NUM_REQ;
    req_valid = '0;
    wait_idle("to");
    check_scoreboard("to");
  endtask

  task automatic test_ext_busy();
    bit got, saw;
    int idle, dv_cnt;
    ext_busy    = 1'b1;
    req_byte[3] = 8'($urandom_range(0, 255));
    req_valid   = 4'b1000;
    dv_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (Data_Valid) dv_cnt++;
    end
    checks++;
    if (dv_cnt != 0 || ARB_BUSY !== 1'b0) begin
      failures++; $display("FAIL ext_block: got launches=%0d busy=%b required 0 0", dv_cnt, ARB_BUSY);
    end
    ext_busy = 1'b0;
    wait_launch(2, got, idle, saw);
    checks++;
    if (!got) begin
      failures++; $display("FAIL ext_release: no launch within 2 cycles of TX_BUSY low");
    end
    check_launch("ext", 3, req_byte[3]);
    exp_q.push_back(req_byte[3]);
    model_ptr = 0;
    req_valid = '0;
    wait_idle("ext");
    check_scoreboard("ext");
  endtask

  task automatic test_reset_mid();
    bit got, saw, busy_seen;
    int idle, w;
    logic [NUM_REQ-1:0] mask;
    req_byte[3] = 8'($urandom_range(0, 255)) | 8'h01;
    req_valid   = 4'b1000;
    wait_launch(10, got, idle, saw);
    check_launch("mid_launch", 3, req_byte[3]);
    exp_q.push_back(req_byte[3]);
    req_valid = '0;
    busy_seen = 1'b0;
    for (int c = 0; c < 10 && !busy_seen; c++) begin
      step();
      if (TX_BUSY) busy_seen = 1'b1;
    end
    step();
    #2 RST = 1'b0;
    #1;
    checks++;
    if ({REQ_ACK, P_DATA, Data_Valid, GRANT_ID, ARB_BUSY, TO_ERR} !== '0 || !busy_seen) begin
      failures++;
      $display("FAIL mid_reset: got ack=%b pdata=%0h dv=%b gid=%0d busy=%b to=%b (uart busy seen=%b) required all 0",
               REQ_ACK, P_DATA, Data_Valid, GRANT_ID, ARB_BUSY, TO_ERR, busy_seen);
    end
    mask = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
    for (int i = 0; i < NUM_REQ; i++) req_byte[i] = 8'($urandom_range(0, 255));
    req_valid = mask;
    step();
    RST = 1'b1;
    model_ptr = 0;
    wait_launch(5, got, idle, saw);
    checks++;
    if (!got) begin
      failures++; $display("FAIL mid_relaunch: no launch within 5 cycles after reset release");
    end
    w = rr_pick(model_ptr, mask);
    check_launch("mid_first", w, req_byte[w]);
    exp_q.push_back(req_byte[w]);
    model_ptr = (w + 1) % NUM_REQ;
    req_valid = '0;
    wait_idle("mid");
    check_scoreboard("mid");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks    = 0;
    failures  = 0;
    model_ptr = 0;
    RST       = 1'b1;
    req_valid = '0;
    uart_en   = 1'b1;
    ext_busy  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) req_byte[i] = '0;
    #1 RST = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_random();
    test_timeout();
    test_ext_busy();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
